// File: rtl/posit_extract_pkg.sv
// Shared definitions for the extract/shift scheduler: mode encodings, request payload, limits.
package posit_extract_pkg;

  localparam logic [1:0] MODE_Q8  = 2'b00;
  localparam logic [1:0] MODE_H16 = 2'b01;
  localparam logic [1:0] MODE_W32 = 2'b10;
  localparam logic [1:0] MODE_ILL = 2'b11;

  localparam logic [7:0] STARVE_MAX = 8'd255;

  // Widest tag the payload can carry; narrower tags sit in the low bits.
  localparam int unsigned TagMaxW = 16;

  typedef struct packed {
    logic [31:0]        data;
    logic [1:0]         mode;
    logic [15:0]        cpm;
    logic [9:0]         cph;
    logic [4:0]         cps;
    logic [TagMaxW-1:0] tag;
  } req_payload_t;

endpackage

// File: rtl/lane_shifter.sv
// Combinational per-lane left shifter: shift by count+1, zero fill, lane cleared on overshift.
module lane_shifter
  import posit_extract_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  mode_i,
  input  logic [15:0] cpm_i,
  input  logic [9:0]  cph_i,
  input  logic [4:0]  cps_i,
  output logic [31:0] data_o
);

  logic [5:0] eff;

  always_comb begin
    data_o = '0;
    eff    = '0;
    case (mode_i)
      MODE_W32: begin
        eff = {1'b0, cps_i} + 6'd1;
        if (eff < 6'd32) data_o = data_i << eff[4:0];
      end
      MODE_H16: begin
        for (int h = 0; h < 2; h++) begin
          eff = {1'b0, cph_i[5*h +: 5]} + 6'd1;
          if (eff < 6'd16) data_o[16*h +: 16] = data_i[16*h +: 16] << eff[3:0];
        end
      end
      default: begin  // byte lanes; the illegal mode also lands here
        for (int k = 0; k < 4; k++) begin
          eff = {2'b0, cpm_i[4*k +: 4]} + 6'd1;
          if (eff < 6'd8) data_o[8*k +: 8] = data_i[8*k +: 8] << eff[2:0];
        end
      end
    endcase
  end

endmodule

// File: rtl/extract_shift_sched.sv
// Two-requester round-robin scheduler feeding a 2-stage lane-shift pipeline with
// per-requester starvation counters.
module extract_shift_sched
  import posit_extract_pkg::*;
#(
  parameter int unsigned TAG_W = 4  // at most TagMaxW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_data,
  input  logic [1:0]       req0_mode,
  input  logic [15:0]      req0_cpm,
  input  logic [9:0]       req0_cph,
  input  logic [4:0]       req0_cps,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_data,
  input  logic [1:0]       req1_mode,
  input  logic [15:0]      req1_cpm,
  input  logic [9:0]       req1_cph,
  input  logic [4:0]       req1_cps,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_src,
  output logic             out_err,
  output logic             busy,
  output logic [7:0]       starve_cnt0,
  output logic [7:0]       starve_cnt1
);

  req_payload_t     pay0, pay1, s1_pay_q, s1_pay_d;
  logic             s1_valid_q, s1_valid_d, s1_src_q, s1_src_d;
  logic             s2_valid_q, s2_valid_d, s2_src_q, s2_src_d, s2_err_q, s2_err_d;
  logic [31:0]      s2_data_q, s2_data_d, shift_res;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic             rr_q, rr_d;
  logic [7:0]       starve0_q, starve0_d, starve1_q, starve1_d;
  logic             s2_adv, s1_take, pick0, pick1, gnt0, gnt1;
  logic             unused_tag_hi;

  always_comb begin
    pay0                 = '0;
    pay0.data            = req0_data;
    pay0.mode            = req0_mode;
    pay0.cpm             = req0_cpm;
    pay0.cph             = req0_cph;
    pay0.cps             = req0_cps;
    pay0.tag[TAG_W-1:0]  = req0_tag;
    pay1                 = '0;
    pay1.data            = req1_data;
    pay1.mode            = req1_mode;
    pay1.cpm             = req1_cpm;
    pay1.cph             = req1_cph;
    pay1.cps             = req1_cps;
    pay1.tag[TAG_W-1:0]  = req1_tag;
  end

  // rr_q=1 means requester 1 wins a tie.
  always_comb begin
    s2_adv  = !s2_valid_q || out_ready;
    s1_take = !s1_valid_q || s2_adv;
    pick1   = req1_valid && (!req0_valid || rr_q);
    pick0   = req0_valid && !pick1;
    gnt0    = rst_n && s1_take && pick0;
    gnt1    = rst_n && s1_take && pick1;
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_src_d   = s1_src_q;
    s1_pay_d   = s1_pay_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_tag_d   = s2_tag_q;
    s2_src_d   = s2_src_q;
    s2_err_d   = s2_err_q;
    rr_d       = rr_q;

    if (s1_take) begin
      s1_valid_d = gnt0 || gnt1;
      if (gnt0) begin
        s1_pay_d = pay0;
        s1_src_d = 1'b0;
        rr_d     = 1'b1;
      end else if (gnt1) begin
        s1_pay_d = pay1;
        s1_src_d = 1'b1;
        rr_d     = 1'b0;
      end
    end

    // Result fields only move with a real entry so a bubble never disturbs them.
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = shift_res;
        s2_tag_d  = s1_pay_q.tag[TAG_W-1:0];
        s2_src_d  = s1_src_q;
        s2_err_d  = (s1_pay_q.mode == MODE_ILL);
      end
    end

    if (gnt0)                                         starve0_d = '0;
    else if (req0_valid && (starve0_q != STARVE_MAX)) starve0_d = starve0_q + 8'd1;
    else                                              starve0_d = starve0_q;

    if (gnt1)                                         starve1_d = '0;
    else if (req1_valid && (starve1_q != STARVE_MAX)) starve1_d = starve1_q + 8'd1;
    else                                              starve1_d = starve1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_src_q   <= 1'b0;
      s1_pay_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_tag_q   <= '0;
      s2_src_q   <= 1'b0;
      s2_err_q   <= 1'b0;
      rr_q       <= 1'b0;
      starve0_q  <= '0;
      starve1_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_src_q   <= s1_src_d;
      s1_pay_q   <= s1_pay_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_tag_q   <= s2_tag_d;
      s2_src_q   <= s2_src_d;
      s2_err_q   <= s2_err_d;
      rr_q       <= rr_d;
      starve0_q  <= starve0_d;
      starve1_q  <= starve1_d;
    end
  end

  lane_shifter u_lane_shifter (
    .data_i (s1_pay_q.data),
    .mode_i (s1_pay_q.mode),
    .cpm_i  (s1_pay_q.cpm),
    .cph_i  (s1_pay_q.cph),
    .cps_i  (s1_pay_q.cps),
    .data_o (shift_res)
  );

  assign unused_tag_hi = ^s1_pay_q.tag;

  assign out_valid   = s2_valid_q;
  assign out_data    = s2_data_q;
  assign out_tag     = s2_tag_q;
  assign out_src     = s2_src_q;
  assign out_err     = s2_err_q;
  assign busy        = s1_valid_q || s2_valid_q;
  assign starve_cnt0 = starve0_q;
  assign starve_cnt1 = starve1_q;

endmodule
